// File: rtl/ctrl_pipe_pkg.sv
// Shared constants and types for the execute-side control pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ctrl_pipe_pkg;

    // Stage indices after decode: execute, memory, writeback.
    localparam int STG_E = 0;
    localparam int STG_M = 1;
    localparam int STG_W = 2;

    // Multi-cycle sequencer: IDLE while stage 0 flows, BUSY while a long op occupies it.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mcState_t;

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Bundle of decode-side inputs and per-stage control outputs of ctrl_pipeline.
// Latency: n/a (wires only).
// Backpressure: stallD/stallE flow back to the decode side; flush_req flows in.
interface ctrl_pipeline_if #(
    parameter int W      = 13,
    parameter int NSTAGE = 3
);
    logic [W-1:0]        ctrlD;
    logic                validD;
    logic                mcD;
    logic                stall_req;
    logic [NSTAGE-1:0]   flush_req;
    logic [NSTAGE*W-1:0] ctrl_o;
    logic [NSTAGE-1:0]   valid_o;
    logic                stallD;
    logic                stallE;
    logic                mc_busy;
    logic                mc_done;

    // Decode/hazard side: drives instructions and requests, watches the stalls.
    modport master (
        output ctrlD, validD, mcD, stall_req, flush_req,
        input  ctrl_o, valid_o, stallD, stallE, mc_busy, mc_done
    );

    // Pipeline side.
    modport slave (
        input  ctrlD, validD, mcD, stall_req, flush_req,
        output ctrl_o, valid_o, stallD, stallE, mc_busy, mc_done
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: holds {mc, valid, ctrl} for a single stage.
// Latency: 1 cycle from d to q when enabled.
// Backpressure: en=0 holds the stage; clr wins over en and loads a bubble.
module pipe_stage_reg #(
    parameter int N = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Bubble on clear (flush beats hold), otherwise load when enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control-bundle pipeline after decode with a stage-0 multi-cycle op sequencer.
// Latency: 1 cycle per stage; a multi-cycle op occupies stage 0 for MC_CYCLES+1 cycles.
// Backpressure: only stage 0 stalls; stallD freezes decode, later stages advance or flush.
module ctrl_pipeline
    import ctrl_pipe_pkg::*;
#(
    parameter int W         = 13,
    parameter int NSTAGE    = 3,   // legal 2..8
    parameter int MC_CYCLES = 32   // legal 1..255
) (
    input  logic            clk,
    input  logic            rst,
    ctrl_pipeline_if.slave  bus
);

    // Wide enough to hold MC_CYCLES-1 without wrapping.
    localparam int CW = $clog2(MC_CYCLES + 1);

    // Each stage word is {mc, valid, ctrl}.
    logic [W+1:0] stageQ   [NSTAGE];
    logic [W+1:0] stageD   [NSTAGE];
    logic         stageEn  [NSTAGE];
    logic         stageClr [NSTAGE];

    mcState_t     state;
    mcState_t     stateNext;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cntNext;
    logic         mcBusyQ;
    logic         stall0;
    logic         done;
    logic         valid0;
    logic         mc0;
    logic         flush0;

    assign valid0 = stageQ[STG_E][W];
    assign mc0    = stageQ[STG_E][W+1];
    assign flush0 = bus.flush_req[STG_E];

    // Sequencer outputs: stage-0 hold request and the completion pulse.
    always_comb begin
        stall0 = ((state == IDLE) && valid0 && mc0 && !flush0) ||
                 ((state == BUSY) && (cnt != '0));
        done   = (state == BUSY) && (cnt == '0) && !flush0;
    end

    // Sequencer next state: start on a fresh stall, count down, abort on flush.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (stall0) begin
                    stateNext = BUSY;
                    cntNext   = CW'(MC_CYCLES - 1);
                end
            end
            BUSY: begin
                if (flush0 || (cnt == '0)) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt - CW'(1);
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    // Sequencer state register; mc_busy is registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            mcBusyQ <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            mcBusyQ <= (stateNext == BUSY);
        end
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : gStage
        if (k == STG_E) begin : gHead
            // Stage 0 takes decode; load-use stall inserts a bubble unless stage 0 is held.
            assign stageD[k]   = {bus.mcD, bus.validD, bus.ctrlD};
            assign stageEn[k]  = !stall0;
            assign stageClr[k] = bus.flush_req[k] | (!stall0 & bus.stall_req);
        end else if (k == STG_M) begin : gAfterHead
            // A held stage 0 leaves a bubble behind it.
            assign stageD[k]   = stageQ[k-1];
            assign stageEn[k]  = 1'b1;
            assign stageClr[k] = bus.flush_req[k] | stall0;
        end else begin : gTail
            assign stageD[k]   = stageQ[k-1];
            assign stageEn[k]  = 1'b1;
            assign stageClr[k] = bus.flush_req[k];
        end

        pipe_stage_reg #(.N(W + 2)) uStage (
            .clk (clk),
            .rst (rst),
            .en  (stageEn[k]),
            .clr (stageClr[k]),
            .d   (stageD[k]),
            .q   (stageQ[k])
        );

        assign bus.ctrl_o[k*W +: W] = stageQ[k][W-1:0];
        assign bus.valid_o[k]       = stageQ[k][W];
    end

    assign bus.stallE  = stall0;
    assign bus.stallD  = bus.stall_req | stall0;
    assign bus.mc_busy = mcBusyQ;
    assign bus.mc_done = done;

endmodule
